pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sequences reset and lock qualification for the SDRAM PLL; runs on the free-running 50 MHz reference clock.
- Drives the PLL reset input, then waits for a qualified (filtered) lock.
- Releases a synchronous reset to the 100 MHz SDRAM clock domain only once lock is qualified.
- Detects loss of lock and lock timeout, re-runs the sequence on either, and keeps lock-loss/timeout counters for software.

Parameters:
- PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (min 1).
- LOCK_FILTER_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release (min 1).
- LOCK_TIMEOUT_CYCLES, 65536, max refclk cycles in WAIT_LOCK before retrying (min 2).
- CNT_W, 8, width of the status counters.

Ports:
- refclk  in  1  reference clock, 50 MHz, the only clock
- rst  in  1  synchronous active-high reset
- pll_locked  in  1  PLL locked output, asynchronous to refclk
- pll_rst  out  1  PLL reset request
- domain_rst  out  1  reset for PLL-clocked logic (active high)
- ready  out  1  high while lock is qualified and the domain is released
- relock_count  out  CNT_W  lock losses seen in RUN, saturating
- timeout_count  out  CNT_W  WAIT_LOCK timeouts, saturating
- fault  out  1  retry limit reached (optional feature only; else tied 0)

Behaviour:
- Clock and reset: one clock, refclk. rst is synchronous and active-high, sampled on the rising edge of refclk.
- Lock synchronizer:
  - pll_locked passes through a 2-flop synchronizer; the output is lk_s.
  - Both flops reset to 0.
  - All FSM decisions use lk_s only.
- Reset values (cycle where rst is sampled high and after):
  - state = RESET_PLL; pll_rst = 1; domain_rst = 1; ready = 0.
  - Counters = 0; fault = 0; internal timer = 0.
- rst mid-operation: same effect from any state; counters clear.
- Outputs are registered and decoded from the state:
  - pll_rst = (state == RESET_PLL)
  - domain_rst = (state != RUN)
  - ready = (state == RUN)
- States and transitions:
  - RESET_PLL:
    - Timer counts 0..PLL_RST_CYCLES-1, so pll_rst is high for exactly PLL_RST_CYCLES cycles.
    - Then go to WAIT_LOCK with the timer cleared.
  - WAIT_LOCK:
    - If lk_s = 1: go to FILTER with the timer cleared.
    - Else if the timer reaches LOCK_TIMEOUT_CYCLES-1: increment timeout_count (saturating) and go to RESET_PLL.
    - Else increment the timer.
  - FILTER:
    - If lk_s = 0: go to WAIT_LOCK with the timer cleared. The timeout window restarts; this is not counted as a timeout.
    - If lk_s = 1 and the timer reaches LOCK_FILTER_CYCLES-1: go to RUN.
    - Net effect: domain_rst falls LOCK_FILTER_CYCLES cycles after the first lk_s-high cycle seen in WAIT_LOCK, plus one cycle for the transition into FILTER.
  - RUN:
    - If lk_s = 0 on any cycle: increment relock_count (saturating) and go to RESET_PLL. domain_rst rises on the next edge.
    - No filtering is applied to lock loss.
- Simultaneous events:
  - rst has priority over every transition.
  - In WAIT_LOCK, lk_s = 1 on the timeout cycle goes to FILTER; no timeout is counted.
- Saturation: counters stop at 2^CNT_W-1 and never wrap.
- Timer width: wide enough for max(PLL_RST_CYCLES, LOCK_FILTER_CYCLES, LOCK_TIMEOUT_CYCLES).

Optional Feature:
Macro PLL_SEQ_RETRY_LIMIT_EN.
- Defined:
  - Adds parameter MAX_RETRIES (default 4) and a FAULT state.
  - A retry counter increments on every WAIT_LOCK timeout and every RUN lock loss.
  - The retry counter clears on entry to RUN after LOCK_FILTER_CYCLES good cycles.
  - When an increment would make the retry counter equal to MAX_RETRIES, go to FAULT instead of RESET_PLL.
  - FAULT: pll_rst = 1, domain_rst = 1, ready = 0, fault = 1. Left only by rst.
- Not defined: no FAULT state, fault tied 0, retries are unlimited.

Test Plan:
Simulation parameters for all scenarios: PLL_RST_CYCLES = 4, LOCK_FILTER_CYCLES = 8, LOCK_TIMEOUT_CYCLES = 32.
- Nominal bring-up: rst 1 for 2 cycles; pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; domain_rst falls 2 (sync) + 1 + 8 cycles after the pll_locked edge; ready = 1; both counters 0.
- Lock glitch during FILTER: pll_locked high 5 cycles, low 1, then high -> returns to WAIT_LOCK; release occurs 8 good cycles after the re-rise; timeout_count stays 0.
- Timeout: pll_locked held 0 -> after 32 WAIT_LOCK cycles pll_rst pulses 4 cycles again; timeout_count = 1, then 2 after the next window; domain_rst stays 1 throughout.
- Lock loss in RUN: drop pll_locked for 1 cycle -> domain_rst rises 3 cycles later (2 sync + 1); relock_count = 1; a full sequence re-runs.
- Saturation with CNT_W = 2: force 5 timeouts -> timeout_count reads 3 and holds.
- With PLL_SEQ_RETRY_LIMIT_EN and MAX_RETRIES = 2: two timeouts -> fault = 1, pll_rst = 1, no further pulses; rst clears fault and restarts the sequence.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives the SDRAM PLL reset, qualifies lock through a
// synchronizer and a consecutive-cycle filter, and releases the PLL-clocked
// domain reset only once lock is qualified. Lock loss and lock timeout both
// re-run the sequence and are tallied in saturating status counters.
// Single clock (refclk), synchronous active-high rst.
// Optional feature: define PLL_SEQ_RETRY_LIMIT_EN to add a MAX_RETRIES limit
// and a FAULT state that is left only through rst.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 8
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  , parameter int MAX_RETRIES       = 4
`endif
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             domain_rst,
  output logic             ready,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic             fault
);

  // Timer must hold values up to max(cycle parameters) - 1.
  localparam int TMR_MAX_A = (PLL_RST_CYCLES > LOCK_FILTER_CYCLES) ? PLL_RST_CYCLES
                                                                   : LOCK_FILTER_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > LOCK_TIMEOUT_CYCLES) ? TMR_MAX_A
                                                               : LOCK_TIMEOUT_CYCLES;
  localparam int TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] FLT_LAST = TMR_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_FILTER    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam logic [2:0] S_FAULT     = 3'd4;
  localparam int         RETRY_W     = $clog2(MAX_RETRIES + 1);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic             sync1_q, lk_s_q;
  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             pll_rst_q, pll_rst_d;
  logic             domain_rst_q, domain_rst_d;
  logic             ready_q, ready_d;
  logic [2:0]       retry_next;   // where a timeout or lock loss sends the FSM
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               fault_q, fault_d;
`endif

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_s_q  <= sync1_q;
    end
  end

  // Retry bookkeeping: decide whether a failed attempt retries or faults.
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  always_comb begin
    retry_inc  = retry_q + 1'b1;
    retry_next = (retry_inc == RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_RESET_PLL;
  end
`else
  always_comb begin
    retry_next = S_RESET_PLL;
  end
`endif

  // Next-state, timer and counter logic; outputs decoded from the next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lk_s_q) begin
          // Lock on the timeout cycle wins; no timeout is counted.
          state_d = S_FILTER;
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          state_d   = retry_next;
          timer_d   = '0;
          timeout_d = sat_inc(timeout_q);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          retry_d   = retry_inc;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FILTER: begin
        if (!lk_s_q) begin
          // A glitch restarts the timeout window; it is not a timeout.
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == FLT_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          retry_d = '0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
        // Lock loss is acted on immediately, without filtering.
        if (!lk_s_q) begin
          state_d  = retry_next;
          timer_d  = '0;
          relock_d = sat_inc(relock_q);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          retry_d  = retry_inc;
`endif
        end
      end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_RESET_PLL;
        timer_d = '0;
      end
    endcase

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    fault_d   = (state_d == S_FAULT);
`else
    pll_rst_d = (state_d == S_RESET_PLL);
`endif
    domain_rst_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_RESET_PLL;
      timer_q      <= '0;
      relock_q     <= '0;
      timeout_q    <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= 1'b1;
      ready_q      <= 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      retry_q      <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      relock_q     <= relock_d;
      timeout_q    <= timeout_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      retry_q      <= retry_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign pll_rst       = pll_rst_q;
  assign domain_rst    = domain_rst_q;
  assign ready         = ready_q;
  assign relock_count  = relock_q;
  assign timeout_count = timeout_q;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  assign fault         = fault_q;
`else
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with PLL_RST_CYCLES=4,
// LOCK_FILTER_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, CNT_W=2.
// Inputs are driven and outputs sampled 1 ns after each rising edge;
// edge numbers in comments count rising edges from time zero.
module tb_pll_reset_sequencer;

  localparam int CNT_W = 2;

  logic             refclk = 1'b0;
  logic             rst = 1'b1;
  logic             pll_locked = 1'b0;
  logic             pll_rst, domain_rst, ready, fault;
  logic [CNT_W-1:0] relock_count, timeout_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_FILTER_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W              (CNT_W)
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    , .MAX_RETRIES      (2)
`endif
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_count(timeout_count),
    .fault        (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to 1 ns after rising edge number e.
  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge refclk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    // ---- Reset for two edges ----
    wait_to(2);
    check("rst_pll_rst",    32'(pll_rst), 32'd1);
    check("rst_domain_rst", 32'(domain_rst), 32'd1);
    check("rst_ready",      32'(ready), 32'd0);
    check("rst_relock",     32'(relock_count), 32'd0);
    check("rst_timeout",    32'(timeout_count), 32'd0);
    check("rst_fault",      32'(fault), 32'd0);
    rst = 1'b0;

    // ---- Nominal bring-up: pll_rst high exactly 4 cycles ----
    for (int e = 3; e <= 5; e++) begin
      wait_to(e);
      check("nom_pll_rst_hi", 32'(pll_rst), 32'd1);
    end
    wait_to(6);
    check("nom_pll_rst_lo",  32'(pll_rst), 32'd0);
    check("nom_dom_rst_wait", 32'(domain_rst), 32'd1);
    // Lock rises 10 cycles after pll_rst fell; release 2+1+8 edges later.
    wait_to(15);
    pll_locked = 1'b1;
    wait_to(25);
    check("nom_dom_rst_before", 32'(domain_rst), 32'd1);
    check("nom_ready_before",   32'(ready), 32'd0);
    wait_to(26);
    check("nom_dom_rst_rel", 32'(domain_rst), 32'd0);
    check("nom_ready",       32'(ready), 32'd1);
    check("nom_relock",      32'(relock_count), 32'd0);
    check("nom_timeout",     32'(timeout_count), 32'd0);

    // ---- Lock loss in RUN: one-cycle drop, domain_rst rises 3 edges later ----
    pll_locked = 1'b0;
    wait_to(27);
    pll_locked = 1'b1;
    check("loss_dom_rst_e1", 32'(domain_rst), 32'd0);
    wait_to(28);
    check("loss_ready_e2",   32'(ready), 32'd1);
    wait_to(29);
    check("loss_dom_rst",    32'(domain_rst), 32'd1);
    check("loss_ready",      32'(ready), 32'd0);
    check("loss_pll_rst",    32'(pll_rst), 32'd1);
    check("loss_relock",     32'(relock_count), 32'd1);
    pll_locked = 1'b0;
    wait_to(32);
    check("loss_pll_rst_hold", 32'(pll_rst), 32'd1);
    wait_to(33);
    check("loss_pll_rst_lo",   32'(pll_rst), 32'd0);

    // ---- Glitch during FILTER: high 5, low 1, then high ----
    pll_locked = 1'b1;
    wait_to(38);
    pll_locked = 1'b0;
    wait_to(39);
    pll_locked = 1'b1;
    wait_to(45);
    check("glitch_no_early_rel", 32'(domain_rst), 32'd1);
    wait_to(49);
    check("glitch_dom_rst_before", 32'(domain_rst), 32'd1);
    wait_to(50);
    check("glitch_dom_rst_rel", 32'(domain_rst), 32'd0);
    check("glitch_ready",       32'(ready), 32'd1);
    check("glitch_timeout",     32'(timeout_count), 32'd0);
    check("glitch_relock",      32'(relock_count), 32'd1);

    // ---- rst mid-operation clears everything ----
    rst = 1'b1;
    pll_locked = 1'b0;
    wait_to(51);
    check("midrst_pll_rst", 32'(pll_rst), 32'd1);
    check("midrst_dom_rst", 32'(domain_rst), 32'd1);
    check("midrst_ready",   32'(ready), 32'd0);
    check("midrst_relock",  32'(relock_count), 32'd0);
    check("midrst_timeout", 32'(timeout_count), 32'd0);
    rst = 1'b0;
    wait_to(54);
    check("midrst_pll_rst_hold", 32'(pll_rst), 32'd1);
    wait_to(55);
    check("midrst_pll_rst_lo",   32'(pll_rst), 32'd0);

    // ---- Timeout: lock held low, 32-cycle windows ----
    wait_to(86);
    check("to1_before_cnt",  32'(timeout_count), 32'd0);
    check("to1_before_prst", 32'(pll_rst), 32'd0);
    wait_to(87);
    check("to1_cnt",     32'(timeout_count), 32'd1);
    check("to1_pll_rst", 32'(pll_rst), 32'd1);
    check("to1_dom_rst", 32'(domain_rst), 32'd1);
    wait_to(90);
    check("to1_pulse_hold", 32'(pll_rst), 32'd1);
    wait_to(91);
    check("to1_pulse_end",  32'(pll_rst), 32'd0);
    wait_to(122);
    check("to2_before_cnt", 32'(timeout_count), 32'd1);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    // ---- Retry limit: second timeout faults ----
    wait_to(123);
    check("flt_fault",   32'(fault), 32'd1);
    check("flt_pll_rst", 32'(pll_rst), 32'd1);
    check("flt_dom_rst", 32'(domain_rst), 32'd1);
    check("flt_ready",   32'(ready), 32'd0);
    check("flt_timeout", 32'(timeout_count), 32'd2);
    wait_to(200);
    check("flt_sticky",       32'(fault), 32'd1);
    check("flt_pll_rst_hold", 32'(pll_rst), 32'd1);
    check("flt_no_more_to",   32'(timeout_count), 32'd2);
    rst = 1'b1;
    wait_to(201);
    check("flt_rst_fault",   32'(fault), 32'd0);
    check("flt_rst_pll_rst", 32'(pll_rst), 32'd1);
    check("flt_rst_timeout", 32'(timeout_count), 32'd0);
    rst = 1'b0;
    wait_to(204);
    check("flt_restart_hold", 32'(pll_rst), 32'd1);
    wait_to(205);
    check("flt_restart_lo",   32'(pll_rst), 32'd0);
`else
    wait_to(123);
    check("to2_cnt",     32'(timeout_count), 32'd2);
    check("to2_dom_rst", 32'(domain_rst), 32'd1);
    // ---- Saturation at 3 with CNT_W=2 ----
    wait_to(159);
    check("to3_cnt", 32'(timeout_count), 32'd3);
    wait_to(195);
    check("to4_sat", 32'(timeout_count), 32'd3);
    wait_to(231);
    check("to5_sat",     32'(timeout_count), 32'd3);
    check("to5_dom_rst", 32'(domain_rst), 32'd1);
    check("to5_ready",   32'(ready), 32'd0);
    check("to5_relock",  32'(relock_count), 32'd0);
    check("to5_fault",   32'(fault), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
